bcd_share_sched: RTL and testbench

- Scheduler that shares one binary-to-BCD conversion engine (shift/add-3 datapath plus its controller) among NREQ requesters.
- Round-robin arbitration across requesters; launches the engine with a one-cycle init pulse and supervises completion with a timeout.
- Returns units/tens digits, requester id and a status code on a valid/ready response channel.
- Sits between the display/status producers and the single BCD engine instance.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/bcd_share_sched.sv | 128 ++++++++++++
 tb/tb_bcd_share_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD engine scheduler: FSM states, status codes, digit width.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  localparam int DIGIT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] id
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bcd_share_sched.sv
// Shares one binary-to-BCD engine among NREQ requesters: round-robin grant,
// range check, launch, timeout supervision and a valid/ready response channel.
module bcd_share_sched
  import bcd_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 7,
  parameter int MAXVAL  = 99,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      conv_init,
  output logic                      conv_abort,
  output logic [WIDTH-1:0]          conv_data,
  input  logic                      conv_done,
  input  logic [DIGIT_W-1:0]        conv_und,
  input  logic [DIGIT_W-1:0]        conv_dec,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [DIGIT_W-1:0]        rsp_und,
  output logic [DIGIT_W-1:0]        rsp_dec,
  output logic [1:0]                rsp_err,
  output logic                      busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;
  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_id;
  logic [WIDTH-1:0] gnt_data;

  function automatic logic out_of_range(input logic [WIDTH-1:0] v);
    return int'(v) > MAXVAL;
  endfunction

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt),
    .id    (gnt_id)
  );

  assign gnt_data  = req_data[int'(gnt_id)*WIDTH +: WIDTH];
  assign req_ready = (state == IDLE) ? gnt : '0;

  // conv_data doubles as the latched operand: it is loaded at grant and
  // therefore stable through LAUNCH and WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      conv_init  <= 1'b0;
      conv_abort <= 1'b0;
      conv_data  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_und    <= '0;
      rsp_dec    <= '0;
      rsp_err    <= ERR_OK;
      busy       <= 1'b0;
    end else begin
      conv_init  <= 1'b0;
      conv_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|gnt) begin
            rsp_id    <= gnt_id;
            conv_data <= gnt_data;
            busy      <= 1'b1;
            if (out_of_range(gnt_data)) begin
              rsp_und   <= '0;
              rsp_dec   <= '0;
              rsp_err   <= ERR_RANGE;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              conv_init <= 1'b1;
              state     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done arriving on the final timeout cycle still counts as success.
          if (conv_done) begin
            rsp_und   <= conv_und;
            rsp_dec   <= conv_dec;
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            conv_abort <= 1'b1;
            rsp_und    <= '0;
            rsp_dec    <= '0;
            rsp_err    <= ERR_TMO;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= (rsp_id == ID_W'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_share_sched.sv
// Scoreboard bench for bcd_share_sched with a behavioural BCD engine model.
module tb_bcd_share_sched;
  import bcd_pkg::*;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 7;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  conv_init, conv_abort;
  logic [WIDTH-1:0]      conv_data;
  logic                  conv_done = 1'b0;
  logic [3:0]            conv_und = '0, conv_dec = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [1:0]            rsp_id;
  logic [3:0]            rsp_und, rsp_dec;
  logic [1:0]            rsp_err;
  logic                  busy;

  bcd_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXVAL(99), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .conv_init(conv_init), .conv_abort(conv_abort), .conv_data(conv_data),
    .conv_done(conv_done), .conv_und(conv_und), .conv_dec(conv_dec),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_und(rsp_und),
    .rsp_dec(rsp_dec), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; int und; int dec; int err; int cyc;} exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int init_cnt = 0, init_cyc = 0, init_data = 0, abort_cnt = 0, abort_cyc = 0;
  int eng_lat = 2, eng_und = 0, eng_dec = 0;
  bit eng_never = 0;
  bit in_rsp = 0;
  int exp_ord[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Engine model: done with configured digits eng_lat cycles after init.
  initial begin
    forever begin
      @(negedge clk);
      if (conv_init && !eng_never) begin
        repeat (eng_lat) @(negedge clk);
        conv_und  = 4'(eng_und);
        conv_dec  = 4'(eng_dec);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
      end
    end
  end

  // Monitor: compares each response against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        in_rsp = 0;
      end else begin
        if (conv_init) begin
          init_cnt++;
          init_cyc  = cyc;
          init_data = int'(conv_data);
        end
        if (conv_abort) begin
          abort_cnt++;
          abort_cyc = cyc;
        end
        if (rsp_valid) begin
          if (!in_rsp) begin
            in_rsp = 1;
            if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
              chk("rsp_latency", cyc, sb[0].cyc);
              chk("rsp_id", int'(rsp_id), sb[0].id);
              chk("rsp_und", int'(rsp_und), sb[0].und);
              chk("rsp_dec", int'(rsp_dec), sb[0].dec);
              chk("rsp_err", int'(rsp_err), sb[0].err);
            end
          end
          if (rsp_ready) begin
            if (sb.size() > 0) begin
              chk("hs_id", int'(rsp_id), sb[0].id);
              chk("hs_und", int'(rsp_und), sb[0].und);
              chk("hs_dec", int'(rsp_dec), sb[0].dec);
              chk("hs_err", int'(rsp_err), sb[0].err);
              void'(sb.pop_front());
            end
            in_rsp = 0;
          end
        end
      end
    end
  end

  task automatic issue(input int i, input int val, input int eu, input int ed, input int ee,
                       input int lat, input bit push, output int acc);
    @(negedge clk);
    req_valid[i] = 1'b1;
    req_data[i*WIDTH +: WIDTH] = WIDTH'(val);
    acc = -1;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (req_ready[i]) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) chk("grant_timeout", 0, 1);
    else begin
      chk("ready_onehot", int'(req_ready), 1 << i);
      if (push) sb.push_back('{i, eu, ed, ee, acc + lat});
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy && !rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  // All requesters in mask held continuously; grant order checked against exp_ord.
  task automatic run_grants(input logic [NREQ-1:0] mask, input int n);
    int got = 0;
    int g;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'(5);
    req_valid = mask;
    for (int t = 0; t < 500; t++) begin
      #1;
      if (req_ready != '0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        chk("rr_onehot", $countones(req_ready), 1);
        chk("rr_order", g, exp_ord[got]);
        sb.push_back('{g, 5, 0, int'(ERR_OK), cyc + 4});
        got++;
        if (got == n) break;
      end
      @(negedge clk);
    end
    if (got < n) chk("rr_timeout", got, n);
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic chk_zero_outs();
    chk("z_req_ready", int'(req_ready), 0);
    chk("z_conv_init", int'(conv_init), 0);
    chk("z_conv_abort", int'(conv_abort), 0);
    chk("z_conv_data", int'(conv_data), 0);
    chk("z_rsp_valid", int'(rsp_valid), 0);
    chk("z_rsp_id", int'(rsp_id), 0);
    chk("z_rsp_und", int'(rsp_und), 0);
    chk("z_rsp_dec", int'(rsp_dec), 0);
    chk("z_rsp_err", int'(rsp_err), 0);
    chk("z_busy", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, i0, a0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero_outs();
    @(negedge clk);
    rst = 1'b0;

    // Single request: 47 -> 4,7 after 16-cycle engine
    eng_lat = 16; eng_und = 7; eng_dec = 4;
    i0 = init_cnt;
    issue(0, 47, 7, 4, int'(ERR_OK), 18, 1, acc);
    wait_idle();
    chk("single_init_cnt", init_cnt, i0 + 1);
    chk("single_init_cyc", init_cyc, acc + 1);
    chk("single_conv_data", init_data, 47);

    // Range errors on requester 2; 99 converts normally
    i0 = init_cnt;
    issue(2, 100, 0, 0, int'(ERR_RANGE), 1, 1, acc);
    wait_idle();
    issue(2, 127, 0, 0, int'(ERR_RANGE), 1, 1, acc);
    wait_idle();
    chk("range_no_init", init_cnt, i0);
    eng_lat = 3; eng_und = 9; eng_dec = 9;
    issue(2, 99, 9, 9, int'(ERR_OK), 5, 1, acc);
    wait_idle();
    chk("max_init", init_cnt, i0 + 1);

    // Timeout, then done on the last timeout cycle
    eng_never = 1;
    a0 = abort_cnt;
    issue(3, 50, 0, 0, int'(ERR_TMO), 2 + TIMEOUT, 1, acc);
    wait_idle();
    chk("tmo_abort_cnt", abort_cnt, a0 + 1);
    chk("tmo_abort_cyc", abort_cyc, acc + 2 + TIMEOUT);
    eng_never = 0; eng_lat = TIMEOUT; eng_und = 3; eng_dec = 2;
    issue(3, 23, 3, 2, int'(ERR_OK), 2 + TIMEOUT, 1, acc);
    wait_idle();
    chk("edge_no_abort", abort_cnt, a0 + 1);

    // Round robin with all four requesting
    eng_lat = 2; eng_und = 5; eng_dec = 0;
    exp_ord = '{0, 1, 2, 3, 0, 1};
    run_grants(4'b1111, 6);
    wait_idle();

    // Backpressure with requester 1 pending
    rsp_ready = 1'b0;
    eng_lat = 2; eng_und = 2; eng_dec = 1;
    issue(0, 12, 2, 1, int'(ERR_OK), 4, 1, acc);
    req_valid[1] = 1'b1;
    req_data[1*WIDTH +: WIDTH] = WIDTH'(34);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) break;
    end
    chk("bp_rsp_seen", int'(rsp_valid), 1);
    eng_und = 4; eng_dec = 3;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      #1;
      chk("bp_ready1_low", int'(req_ready[1]), 0);
      chk("bp_valid_held", int'(rsp_valid), 1);
      chk("bp_id_held", int'(rsp_id), 0);
      chk("bp_und_held", int'(rsp_und), 2);
      chk("bp_dec_held", int'(rsp_dec), 1);
      chk("bp_err_held", int'(rsp_err), int'(ERR_OK));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_grant1", int'(req_ready), 2);
    sb.push_back('{1, 4, 3, int'(ERR_OK), cyc + 4});
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_idle();

    // Reset mid-WAIT; late done ignored; pointer restarts at 0
    eng_lat = 20; eng_und = 5; eng_dec = 5;
    issue(2, 55, 5, 5, int'(ERR_OK), 22, 0, acc);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero_outs();
    repeat (25) @(negedge clk);
    #1;
    chk("late_done_valid", int'(rsp_valid), 0);
    chk("late_done_busy", int'(busy), 0);
    eng_lat = 2; eng_und = 5; eng_dec = 0;
    exp_ord = '{1, 3, 0, 0, 0, 0};
    run_grants(4'b1010, 2);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
